// File: rtl/q3fsm_pkg.sv
// Shared types and helpers for the q3fsm window logger.
// Optional build macro: LOGGER_HIT_ONLY_EN (see q3fsm_window_logger.sv).
package q3fsm_pkg;

   localparam int IDX_W_DEF = 8;
   localparam int RUN_W_DEF = 4;

   // One logged window result, laid out exactly as it appears on out_data.
   typedef struct packed {
      logic [IDX_W_DEF-1:0] idx;
      logic                 hit;
      logic [RUN_W_DEF-1:0] run;
   } q3fsm_rec_t;

   // Increment that sticks at max instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
      return (v >= max) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/q3fsm_window_logger_if.sv
// Record stream toward the trace sink.
// valid/ready: a record moves on any rising edge where out_valid && out_ready;
// while out_valid && !out_ready the source holds out_data unchanged.
interface q3fsm_window_logger_if #(
   parameter int WIDTH = 13
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/q3fsm_sync_fifo.sv
// Pointer-based synchronous FIFO. Pointers carry one extra wrap bit so that
// level = wptr - rptr covers 0..DEPTH. A push while full is accepted only
// when a pop happens on the same edge.
module q3fsm_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 13,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_level
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [AW:0]      w_level;
   logic             w_pop_eff;
   logic             w_push_eff;

   assign w_level    = r_wptr - r_rptr;
   assign o_level    = w_level;
   assign o_full     = (w_level == (AW+1)'(DEPTH));
   assign o_empty    = (w_level == '0);
   assign w_pop_eff  = i_pop && !o_empty;
   assign w_push_eff = i_push && (!o_full || w_pop_eff);
   assign o_rd_data  = r_mem[r_rptr[AW-1:0]];

   // Storage and pointer update; reset clears contents so out_data reads zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push_eff) begin
            r_mem[r_wptr[AW-1:0]] <= i_push_data;
            r_wptr                <= r_wptr + (AW+1)'(1);
         end
         if (w_pop_eff) r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/q3fsm_window_logger.sv
// Tags each evaluated window result with a wrapping index and a saturating
// hit-run length, buffers the records in a small FIFO toward a trace sink and
// counts records lost because the FIFO was full.
// Optional build macro: LOGGER_HIT_ONLY_EN -- when defined, only hit records
// are pushed; misses still advance the index and clear the run.
module q3fsm_window_logger
   import q3fsm_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int IDX_W  = IDX_W_DEF,
   parameter int RUN_W  = RUN_W_DEF,
   parameter int DROP_W = 8,
   parameter int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  win_done,
   input  logic                  win_hit,
   q3fsm_window_logger_if.master sink,
   output logic [DROP_W-1:0]     drop_cnt,
   output logic [LVL_W-1:0]      fifo_lvl
);

   localparam int          REC_W   = IDX_W + 1 + RUN_W;
   localparam logic [31:0] RUN_MAX = (32'd1 << RUN_W) - 32'd1;

   logic [IDX_W-1:0]  r_idx;
   logic [RUN_W-1:0]  r_run;
   logic [DROP_W-1:0] r_drop;

   logic [RUN_W-1:0]  w_rec_run;
   logic [REC_W-1:0]  w_rec;
   logic              w_push_req;
   logic              w_push_ok;
   logic              w_drop;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;

`ifdef LOGGER_HIT_ONLY_EN
   assign w_push_req = win_done && win_hit;
`else
   assign w_push_req = win_done;
`endif

   assign w_rec_run  = win_hit ? RUN_W'(sat_inc(32'(r_run), RUN_MAX)) : '0;
   assign w_rec      = {r_idx, win_hit, w_rec_run};
   assign w_pop      = sink.out_valid && sink.out_ready;
   assign w_push_ok  = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && !w_push_ok;

   assign sink.out_valid = !w_empty;
   assign drop_cnt       = r_drop;

   q3fsm_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push_ok),
      .i_push_data (w_rec),
      .i_pop       (w_pop),
      .o_rd_data   (sink.out_data),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_level     (fifo_lvl)
   );

   // Window index and hit-run advance on every evaluated window, pushed or not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx <= '0;
         r_run <= '0;
      end else if (win_done) begin
         r_idx <= r_idx + IDX_W'(1);
         r_run <= w_rec_run;
      end
   end

   // Saturating count of records refused because the FIFO had no room.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_drop <= '0;
      end else if (w_drop && (r_drop != '1)) begin
         r_drop <= r_drop + DROP_W'(1);
      end
   end

endmodule
